// File: rtl/mem_responder_if.sv
// Memory handshake between the microcoded controller (master) and mem_responder (slave).
interface mem_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              wait_;
  logic              mem_err;

  modport master (
    output mem_rd, mem_wr, addr, wdata,
    input  rdata, rdata_valid, wait_, mem_err
  );

  modport slave (
    input  mem_rd, mem_wr, addr, wdata,
    output rdata, rdata_valid, wait_, mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word RAM behind the controller's wait_ handshake: wait_ high LATENCY cycles per access, one access per strobe.
// Backpressure is wait_ only; held strobes park in DONE. MEM_ERR_EN adds out-of-range discard and a sticky mem_err.
module mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_op_wr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_valid;
  logic              r_wait;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [IDX_W-1:0]  w_idx;
  logic              w_fire;
  logic              w_oor;
  logic              w_commit;

  assign w_idx  = IDX_W'(32'(r_addr) % DEPTH);
  assign w_fire = (r_state == BUSY) && (r_count == '0);

`ifdef MEM_ERR_EN
  logic r_mem_err;
  assign w_oor       = 32'(r_addr) >= 32'(DEPTH);
  assign bus.mem_err = r_mem_err;
`else
  assign w_oor       = 1'b0;
  assign bus.mem_err = 1'b0;
`endif

  // Gating with rst_n drops a write whose completion edge coincides with reset.
  assign w_commit = rst_n && w_fire && r_op_wr && !w_oor;

  always_ff @(posedge clk) begin
    if (w_commit) r_mem[w_idx] <= r_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_op_wr       <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_wait        <= 1'b0;
`ifdef MEM_ERR_EN
      r_mem_err     <= 1'b0;
`endif
    end else begin
      r_rdata_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.mem_rd || bus.mem_wr) begin
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_op_wr <= bus.mem_wr;
            r_count <= CNT_W'(LATENCY - 1);
            r_wait  <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_count == '0) begin
            r_wait  <= 1'b0;
            r_state <= DONE;
            if (!r_op_wr) begin
              r_rdata       <= w_oor ? '0 : r_mem[w_idx];
              r_rdata_valid <= 1'b1;
            end
`ifdef MEM_ERR_EN
            r_mem_err <= r_mem_err | w_oor;
`endif
          end else begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        DONE: begin
          if (!(bus.mem_rd || bus.mem_wr)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rdata       = r_rdata;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.wait_       = r_wait;
endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: per-cycle timeline model plus literal checks of the directed scenarios.
module tb_mem_responder;
  localparam int AW   = 12;
  localparam int DW   = 16;
  localparam int LAT  = 2;
`ifdef MEM_ERR_EN
  localparam int DEP    = 2048;
  localparam bit ERR_EN = 1'b1;
`else
  localparam int DEP    = 4096;
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int NCYC = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int chk_from = -1;
  int cnt_wait = 0;
  int cnt_valid = 0;

  // Expected outputs per cycle; index = number of rising edges seen.
  bit            exp_wait   [NCYC];
  bit            exp_valid  [NCYC];
  bit            exp_rst    [NCYC];
  bit            exp_rchg   [NCYC];
  bit            exp_errset [NCYC];
  logic [DW-1:0] exp_rval   [NCYC];
  logic [DW-1:0] cur_rdata = '0;
  bit            cur_err = 1'b0;
  logic [DW-1:0] model_mem [int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (bus.wait_ === 1'b1) cnt_wait++;
    if (bus.rdata_valid === 1'b1) cnt_valid++;
  end

  always @(negedge clk) begin
    if (chk_from >= 0 && cyc >= chk_from && cyc < NCYC) begin
      if (exp_rst[cyc]) begin
        cur_rdata = '0;
        cur_err = 1'b0;
      end
      if (exp_rchg[cyc]) cur_rdata = exp_rval[cyc];
      if (exp_errset[cyc]) cur_err = 1'b1;
      chk("wait_", 32'(bus.wait_), 32'(exp_wait[cyc]));
      chk("rdata_valid", 32'(bus.rdata_valid), 32'(exp_valid[cyc]));
      chk("rdata", 32'(bus.rdata), 32'(cur_rdata));
      chk("mem_err", 32'(bus.mem_err), 32'(cur_err));
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    for (int i = cyc + 1; i < cyc + 64 && i < NCYC; i++) begin
      exp_wait[i] = 0; exp_valid[i] = 0; exp_rchg[i] = 0; exp_errset[i] = 0; exp_rst[i] = 0;
    end
    for (int i = 1; i <= n; i++) if (cyc + i < NCYC) exp_rst[cyc + i] = 1'b1;
    if (chk_from < 0) chk_from = cyc + 1;
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One handshake; strobes held for 'hold' edges, then waits until the responder is idle again.
  task automatic do_access(input bit wr, input bit rd, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int hold);
    int a_cyc, c_cyc, x_cyc, idx;
    bit oor;
    @(negedge clk);
    bus.mem_wr = wr;
    bus.mem_rd = rd;
    bus.addr = a;
    bus.wdata = d;
    a_cyc = cyc + 1;
    c_cyc = a_cyc + LAT;
    x_cyc = a_cyc + hold;
    oor = ERR_EN && (int'(a) >= DEP);
    idx = int'(a) % DEP;
    for (int k = 0; k < LAT; k++) if (a_cyc + k < NCYC) exp_wait[a_cyc + k] = 1'b1;
    if (c_cyc < NCYC) begin
      if (rd && !wr) begin
        exp_valid[c_cyc] = 1'b1;
        exp_rchg[c_cyc] = 1'b1;
        exp_rval[c_cyc] = (oor || !model_mem.exists(idx)) ? '0 : model_mem[idx];
      end
      if (oor) exp_errset[c_cyc] = 1'b1;
    end
    if (wr && !oor) model_mem[idx] = d;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (k == hold - 1) begin
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
      end else begin
        bus.addr = AW'($urandom);
        bus.wdata = DW'($urandom);
      end
    end
    while (cyc < ((x_cyc > c_cyc + 1) ? x_cyc : c_cyc + 1)) @(negedge clk);
  endtask

  int w0, v0, a_cyc;
  int pool [16];
  logic [AW-1:0] ra;

  initial begin
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;

    // Reset then write 0xBEEF to 0x005
    do_reset(2);
    chk("rst_wait", 32'(bus.wait_), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    w0 = cnt_wait;
    do_access(1'b1, 1'b0, 12'h005, 16'hBEEF, 1);
    chk("wr_wait_cycles", 32'(cnt_wait - w0), 32'd2);
    chk("wr_rdata_kept", 32'(bus.rdata), 32'd0);

    // Readback
    w0 = cnt_wait; v0 = cnt_valid;
    do_access(1'b0, 1'b1, 12'h005, 16'h0000, 1);
    chk("rd_wait_cycles", 32'(cnt_wait - w0), 32'd2);
    chk("rd_valid_pulses", 32'(cnt_valid - v0), 32'd1);
    chk("rd_value", 32'(bus.rdata), 32'hBEEF);

    // Held strobe: one access only
    v0 = cnt_valid;
    do_access(1'b0, 1'b1, 12'h005, 16'h0000, 10);
    chk("held_valid_pulses", 32'(cnt_valid - v0), 32'd1);

    // Simultaneous strobes act as a write
    v0 = cnt_valid;
    do_access(1'b1, 1'b1, 12'h010, 16'h1234, 1);
    chk("both_no_valid", 32'(cnt_valid - v0), 32'd0);
    do_access(1'b0, 1'b1, 12'h010, 16'h0000, 1);
    chk("both_readback", 32'(bus.rdata), 32'h1234);

    // Reset during the first BUSY cycle aborts the write
    do_access(1'b1, 1'b0, 12'h020, 16'h5555, 1);
    @(negedge clk);
    bus.mem_wr = 1'b1;
    bus.addr = 12'h020;
    bus.wdata = 16'hAAAA;
    a_cyc = cyc + 1;
    exp_wait[a_cyc] = 1'b1;
    do_reset(1);
    chk("abort_wait", 32'(bus.wait_), 32'd0);
    do_access(1'b0, 1'b1, 12'h020, 16'h0000, 1);
    chk("abort_readback", 32'(bus.rdata), 32'h5555);

`ifdef MEM_ERR_EN
    w0 = cnt_wait; v0 = cnt_valid;
    do_access(1'b0, 1'b1, 12'h900, 16'h0000, 1);
    chk("oor_wait_cycles", 32'(cnt_wait - w0), 32'd2);
    chk("oor_valid", 32'(cnt_valid - v0), 32'd1);
    chk("oor_rdata", 32'(bus.rdata), 32'd0);
    chk("oor_err", 32'(bus.mem_err), 32'd1);
    do_access(1'b0, 1'b1, 12'h005, 16'h0000, 1);
    chk("oor_err_sticky", 32'(bus.mem_err), 32'd1);
    chk("legal_after_oor", 32'(bus.rdata), 32'hBEEF);
`else
    chk("err_tied_low", 32'(bus.mem_err), 32'd0);
`endif

    // Random phase over a pre-written address pool
    for (int i = 0; i < 16; i++) begin
      pool[i] = $urandom_range(0, DEP - 1);
      do_access(1'b1, 1'b0, AW'(pool[i]), DW'($urandom), 1);
    end
    for (int t = 0; t < 150; t++) begin
      int op;
      op = $urandom_range(0, 5);
      ra = AW'(pool[$urandom_range(0, 15)]);
      if (ERR_EN && $urandom_range(0, 7) == 0) ra = AW'($urandom_range(DEP, (1 << AW) - 1));
      do_access(op >= 3 || op == 0, op != 0, ra, DW'($urandom), $urandom_range(1, LAT + 4));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 2));
    end
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side end of the microcoded controller's memory handshake.
- Accepts read and write strobes plus address and data from the control word and datapath, then performs the access after a fixed wait-state count.
- Drives `wait_` back to the controller's next-state mux, so microcode loops on `wait_` until the access is done.
- Holds a synchronous word-addressed RAM.

Parameters:
- ADDR_W, 12, address width in words
- DATA_W, 16, data word width
- DEPTH, 4096, number of implemented words; must satisfy DEPTH <= 2**ADDR_W
- LATENCY, 2, number of wait-state cycles per access; must be >= 1

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst_n  input  1  synchronous active-low reset
- mem_rd  input  1  read request, level, from control word
- mem_wr  input  1  write request, level, from control word
- addr  input  ADDR_W  word address, sampled at request acceptance
- wdata  input  DATA_W  write data, sampled at request acceptance
- rdata  output  DATA_W  read data, registered
- rdata_valid  output  1  one-cycle pulse when rdata is updated by a read
- wait_  output  1  1 = access in progress, controller must stall; registered
- mem_err  output  1  sticky out-of-range flag; present only with MEM_ERR_EN, otherwise tied 0

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; wait_=0, rdata=0, rdata_valid=0, mem_err=0; wait counter cleared.
  - RAM contents are not reset.
- Reset mid-access: the access aborts; a pending write is NOT committed.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - At an edge where mem_rd|mem_wr=1, latch addr, wdata and op, then go to BUSY with wait_=1 and count=LATENCY-1.
  - If mem_rd and mem_wr are both 1, the op is a write (write priority).
- BUSY:
  - wait_=1; count decrements each edge.
  - Request inputs are ignored; the latched values are used.
  - At the edge where count=0: perform the access, go to DONE, wait_=0.
    - Write: RAM[addr_l] <= wdata_l.
    - Read: rdata <= RAM[addr_l], rdata_valid=1 for that one cycle.
- Latency: wait_ is high for exactly LATENCY cycles, starting the cycle after acceptance. rdata is valid in the first cycle wait_ is 0.
- DONE:
  - wait_=0; rdata holds its value; rdata_valid=0 after its single cycle.
  - Stay in DONE while mem_rd|mem_wr=1, so a held strobe never causes a second access.
  - Go to IDLE at the edge where both strobes are 0.
- A new request is accepted only in IDLE. The minimum request-to-request spacing is LATENCY+2 cycles.
- rdata changes only on a completed read; writes leave rdata unchanged.
- Addresses >= DEPTH:
  - Without MEM_ERR_EN, behaviour is undefined (index wraps modulo DEPTH).
  - With MEM_ERR_EN, see below.
- Handshake timing is identical for reads and writes.

Optional Feature:
- MEM_ERR_EN defined:
  - An accepted access with addr >= DEPTH completes with normal wait_ timing.
  - Write: discarded, RAM unchanged.
  - Read: returns rdata=0 with rdata_valid pulsed.
  - mem_err is set at the completion edge and stays 1 until reset.
- MEM_ERR_EN undefined: no range compare logic; mem_err is a constant 0.

Test Plan:
- Reset, then write: rst_n=0 for 2 cycles → wait_=0, rdata=0. Then mem_wr=1, addr=0x005, wdata=0xBEEF with LATENCY=2 → wait_=1 for exactly 2 cycles, then 0; rdata remains 0.
- Readback: mem_rd=1, addr=0x005 → wait_ high 2 cycles; in the cycle wait_ falls, rdata=0xBEEF and rdata_valid=1 for 1 cycle only.
- Held strobe: keep mem_rd=1 for 10 cycles → exactly one access (one rdata_valid pulse); FSM stays in DONE until mem_rd=0, then accepts a new request.
- Simultaneous strobes: mem_rd=1, mem_wr=1, addr=0x010, wdata=0x1234 → treated as a write, rdata_valid stays 0; a later read of 0x010 returns 0x1234.
- Reset mid-access: start a write of 0xAAAA to 0x020 (prior content 0x5555), assert rst_n=0 during the first BUSY cycle → wait_=0 next cycle; a later read of 0x020 returns 0x5555.
- MEM_ERR_EN, DEPTH=2048: read at addr=0x900 → normal wait_ timing, rdata=0, rdata_valid=1, mem_err=1 and still 1 after a later legal access.
